// File: rtl/reg_file_hilo.sv
// MIPS register file: 32 general-purpose registers ($0 hardwired to zero) plus the HI/LO pair.
// Read ports are combinational; all state changes on the rising clock edge or on async reset.
module reg_file_hilo #(
    parameter int                DATA_W  = 32,
    parameter logic [DATA_W-1:0] SP_INIT = 32'h0000_3ffc,
    parameter logic [DATA_W-1:0] GP_INIT = 32'h0000_1800,
    parameter bit                BYPASS  = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [4:0]        ra1,
    input  logic [4:0]        ra2,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    input  logic              we,
    input  logic [4:0]        wa,
    input  logic [DATA_W-1:0] wd,
    input  logic [1:0]        hilo_op,
    input  logic [DATA_W-1:0] hi_in,
    input  logic [DATA_W-1:0] lo_in,
    input  logic [DATA_W-1:0] mt_data,
    output logic [DATA_W-1:0] hi_out,
    output logic [DATA_W-1:0] lo_out,
    input  logic [4:0]        dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    localparam logic [1:0] HILO_NONE = 2'b00;
    localparam logic [1:0] HILO_PAIR = 2'b01;
    localparam logic [1:0] HILO_MTHI = 2'b10;
    localparam logic [1:0] HILO_MTLO = 2'b11;

    // Entry 0 is never written and is masked on every read port.
    logic [DATA_W-1:0] gpr_r [0:31];
    logic [DATA_W-1:0] hi_r;
    logic [DATA_W-1:0] lo_r;
    logic              gpr_wr_s;
    logic [DATA_W-1:0] rd1_s;
    logic [DATA_W-1:0] rd2_s;
    logic [DATA_W-1:0] dbg_s;

    function automatic logic [DATA_W-1:0] reset_value(input logic [4:0] idx);
        logic [DATA_W-1:0] val;
        case (idx)
            5'd28:   val = GP_INIT;
            5'd29:   val = SP_INIT;
            default: val = '0;
        endcase
        return val;
    endfunction

    // Forwarding is suppressed while reset is held so outputs show pure reset state.
    function automatic logic [DATA_W-1:0] read_port(
        input logic [4:0]        ra,
        input logic              fwd_en,
        input logic [DATA_W-1:0] stored
    );
        logic [DATA_W-1:0] val;
        if (ra == 5'd0) begin
            val = '0;
        end else if (fwd_en && (wa == ra)) begin
            val = wd;
        end else begin
            val = stored;
        end
        return val;
    endfunction

    // Qualified GPR write strobe; an X on we evaluates as no-write.
    always_comb begin
        gpr_wr_s = 1'b0;
        if (we && (wa != 5'd0)) begin
            gpr_wr_s = 1'b1;
        end else begin
            gpr_wr_s = 1'b0;
        end
    end

    // GPR storage with async load of the architectural reset values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                gpr_r[i] <= reset_value(5'(i));
            end
        end else if (gpr_wr_s) begin
            gpr_r[wa] <= wd;
        end
    end

    // HI/LO update; mthi/mtlo touch only their own half.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_r <= '0;
            lo_r <= '0;
        end else begin
            case (hilo_op)
                HILO_PAIR: begin
                    hi_r <= hi_in;
                    lo_r <= lo_in;
                end
                HILO_MTHI: hi_r <= mt_data;
                HILO_MTLO: lo_r <= mt_data;
                HILO_NONE: begin
                    hi_r <= hi_r;
                    lo_r <= lo_r;
                end
                default: begin
                    hi_r <= hi_r;
                    lo_r <= lo_r;
                end
            endcase
        end
    end

    // Combinational read ports; the debug port never forwards.
    always_comb begin
        rd1_s = '0;
        rd2_s = '0;
        dbg_s = '0;
        rd1_s = read_port(ra1, BYPASS && rst_n && gpr_wr_s, gpr_r[ra1]);
        rd2_s = read_port(ra2, BYPASS && rst_n && gpr_wr_s, gpr_r[ra2]);
        dbg_s = read_port(dbg_addr, 1'b0, gpr_r[dbg_addr]);
    end

    assign rd1      = rd1_s;
    assign rd2      = rd2_s;
    assign dbg_data = dbg_s;
    assign hi_out   = hi_r;
    assign lo_out   = lo_r;

endmodule

// File: tb/tb_reg_file_hilo.sv
// Scoreboard bench for reg_file_hilo: a plain array model predicts every read, two DUT builds
// (no forwarding / forwarding) share the stimulus, and a monitor compares after each drive.
module tb_reg_file_hilo;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [4:0]  ra1 = 5'd0, ra2 = 5'd0, wa = 5'd0, dbg_addr = 5'd0;
    logic        we = 1'b0;
    logic [31:0] wd = 32'd0, hi_in = 32'd0, lo_in = 32'd0, mt_data = 32'd0;
    logic [1:0]  hilo_op = 2'b00;
    logic [31:0] rd1_a, rd2_a, hi_a, lo_a, dbg_a;
    logic [31:0] rd1_b, rd2_b, hi_b, lo_b, dbg_b;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [31:0] rd1, rd2, dbg, hi, lo, brd1, brd2;
    } exp_t;
    exp_t sb_q[$];

    logic [31:0] m_gpr [32];
    logic [31:0] m_hi, m_lo;

    always #5 clk = ~clk;

    reg_file_hilo #(.BYPASS(1'b0)) dut_a (
        .clk(clk), .rst_n(rst_n), .ra1(ra1), .ra2(ra2), .rd1(rd1_a), .rd2(rd2_a),
        .we(we), .wa(wa), .wd(wd), .hilo_op(hilo_op), .hi_in(hi_in), .lo_in(lo_in),
        .mt_data(mt_data), .hi_out(hi_a), .lo_out(lo_a), .dbg_addr(dbg_addr), .dbg_data(dbg_a)
    );

    reg_file_hilo #(.BYPASS(1'b1)) dut_b (
        .clk(clk), .rst_n(rst_n), .ra1(ra1), .ra2(ra2), .rd1(rd1_b), .rd2(rd2_b),
        .we(we), .wa(wa), .wd(wd), .hilo_op(hilo_op), .hi_in(hi_in), .lo_in(lo_in),
        .mt_data(mt_data), .hi_out(hi_b), .lo_out(lo_b), .dbg_addr(dbg_addr), .dbg_data(dbg_b)
    );

    function automatic void model_reset();
        for (int i = 0; i < 32; i++) m_gpr[i] = 32'd0;
        m_gpr[28] = 32'h0000_1800;
        m_gpr[29] = 32'h0000_3ffc;
        m_hi = 32'd0;
        m_lo = 32'd0;
    endfunction

    function automatic logic [31:0] model_read(input logic [4:0] ra, input bit fwd);
        if (ra == 5'd0) return 32'd0;
        if (fwd && rst_n && we && wa == ra) return wd;
        return m_gpr[ra];
    endfunction

    // Apply one cycle of inputs at the falling edge, predict outputs, then advance the model.
    task automatic drive(input logic r, input logic w, input logic [4:0] a_w, input logic [31:0] d_w,
                         input logic [1:0] op, input logic [31:0] h, input logic [31:0] l,
                         input logic [31:0] mt, input logic [4:0] a1, input logic [4:0] a2,
                         input logic [4:0] ad);
        exp_t e;
        @(negedge clk);
        rst_n = r; we = w; wa = a_w; wd = d_w; hilo_op = op;
        hi_in = h; lo_in = l; mt_data = mt; ra1 = a1; ra2 = a2; dbg_addr = ad;
        if (!r) model_reset();
        e.rd1  = model_read(a1, 1'b0);
        e.rd2  = model_read(a2, 1'b0);
        e.dbg  = model_read(ad, 1'b0);
        e.brd1 = model_read(a1, 1'b1);
        e.brd2 = model_read(a2, 1'b1);
        e.hi   = m_hi;
        e.lo   = m_lo;
        sb_q.push_back(e);
        if (r) begin
            if (w && a_w != 5'd0) m_gpr[a_w] = d_w;
            if (op == 2'b01) begin m_hi = h; m_lo = l; end
            else if (op == 2'b10) m_hi = mt;
            else if (op == 2'b11) m_lo = mt;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: outputs are settled 2 time units after each falling-edge drive.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            while (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("rd1_nobyp", rd1_a, e.rd1);
                chk("rd2_nobyp", rd2_a, e.rd2);
                chk("dbg_nobyp", dbg_a, e.dbg);
                chk("hi_nobyp",  hi_a,  e.hi);
                chk("lo_nobyp",  lo_a,  e.lo);
                chk("rd1_byp",   rd1_b, e.brd1);
                chk("rd2_byp",   rd2_b, e.brd2);
                chk("dbg_byp",   dbg_b, e.dbg);
                chk("hi_byp",    hi_b,  e.hi);
                chk("lo_byp",    lo_b,  e.lo);
            end
        end
    end

    initial begin
        #500000;
        n_errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        logic [4:0] a;
        model_reset();
        // Reset held: sweep every register while writes and HI/LO loads are attempted.
        for (int i = 0; i < 32; i++)
            drive(1'b0, 1'b1, 5'(i), 32'hffff_ffff, 2'b01, 32'h11, 32'h22, 32'h33,
                  5'(i), 5'(31 - i), 5'(i));
        // Write $5; same-cycle read returns old value without forwarding, new with it.
        drive(1'b1, 1'b1, 5'd5, 32'hdead_beef, 2'b00, 32'd0, 32'd0, 32'd0, 5'd5, 5'd29, 5'd5);
        drive(1'b1, 1'b0, 5'd0, 32'd0, 2'b00, 32'd0, 32'd0, 32'd0, 5'd5, 5'd28, 5'd5);
        // Writes to $0 are dropped on every port.
        drive(1'b1, 1'b1, 5'd0, 32'hffff_ffff, 2'b00, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0);
        drive(1'b1, 1'b0, 5'd0, 32'd0, 2'b00, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0);
        // HI/LO pair load, then mthi, then mtlo, then hold.
        drive(1'b1, 1'b0, 5'd0, 32'd0, 2'b01, 32'h1, 32'h2, 32'd0, 5'd5, 5'd5, 5'd5);
        drive(1'b1, 1'b0, 5'd0, 32'd0, 2'b10, 32'hff, 32'hee, 32'h7, 5'd5, 5'd5, 5'd5);
        drive(1'b1, 1'b0, 5'd0, 32'd0, 2'b11, 32'hff, 32'hee, 32'h9, 5'd5, 5'd5, 5'd5);
        drive(1'b1, 1'b0, 5'd0, 32'd0, 2'b00, 32'hff, 32'hee, 32'ha, 5'd5, 5'd5, 5'd5);
        // Both read ports on the written address: forwarded per port, debug never forwarded.
        drive(1'b1, 1'b1, 5'd9, 32'h55, 2'b01, 32'h3, 32'h4, 32'd0, 5'd9, 5'd9, 5'd9);
        drive(1'b1, 1'b1, 5'd9, 32'h66, 2'b00, 32'd0, 32'd0, 32'd0, 5'd9, 5'd10, 5'd9);
        // Randomized traffic, biased so read addresses often hit the write address.
        for (int i = 0; i < 400; i++) begin
            a = 5'($urandom_range(0, 31));
            drive(1'b1, 1'($urandom), a, $urandom, 2'($urandom), $urandom, $urandom, $urandom,
                  ($urandom_range(0, 2) == 0) ? a : 5'($urandom),
                  ($urandom_range(0, 2) == 0) ? a : 5'($urandom),
                  ($urandom_range(0, 3) == 0) ? a : 5'($urandom));
        end
        // Async reset between edges after writing $5 and HI; write in flight is lost.
        drive(1'b1, 1'b1, 5'd5, 32'h1234_5678, 2'b10, 32'd0, 32'd0, 32'hcafe_f00d, 5'd5, 5'd29, 5'd5);
        drive(1'b1, 1'b0, 5'd0, 32'd0, 2'b00, 32'd0, 32'd0, 32'd0, 5'd5, 5'd29, 5'd5);
        drive(1'b0, 1'b1, 5'd5, 32'h9999_9999, 2'b01, 32'h5, 32'h6, 32'd0, 5'd5, 5'd28, 5'd5);
        drive(1'b0, 1'b1, 5'd5, 32'h8888_8888, 2'b10, 32'd0, 32'd0, 32'h7, 5'd5, 5'd28, 5'd5);
        drive(1'b1, 1'b0, 5'd0, 32'd0, 2'b00, 32'd0, 32'd0, 32'd0, 5'd5, 5'd29, 5'd28);
        drive(1'b1, 1'b1, 5'd28, 32'h0bad_cafe, 2'b11, 32'd0, 32'd0, 32'h42, 5'd28, 5'd5, 5'd28);
        drive(1'b1, 1'b0, 5'd0, 32'd0, 2'b00, 32'd0, 32'd0, 32'd0, 5'd28, 5'd29, 5'd28);
        @(negedge clk);
        @(negedge clk);
        #4;
        n_checks++;
        if (sb_q.size() != 0) begin
            n_errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
